// File: rtl/controle_calc.sv
// Sequencing controller for the calculator register bank: issues bank writes,
// schedules two-port reads, runs a signed add/subtract and writes the result back.
module controle_calc #(
    parameter int LARGURA = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_inicio,
    input  logic [1:0]         i_comando,
    input  logic [1:0]         i_operacao,
    input  logic [LARGURA-1:0] i_entrada,
    input  logic [LARGURA-1:0] i_dadoLido1,
    input  logic [LARGURA-1:0] i_dadoLido2,
    output logic               o_ocupado,
    output logic               o_pronto,
    output logic [LARGURA-1:0] o_resultado,
    output logic               o_overflow,
    output logic [1:0]         o_idReg,
    output logic               o_escrita,
    output logic [LARGURA-1:0] o_dado,
    output logic [1:0]         o_fonte1,
    output logic [1:0]         o_fonte2
);

    typedef enum logic [2:0] {
        OCIOSO,
        ESCREVE,
        LE,
        ESPERA,
        CALCULA,
        GRAVA,
        FIM
    } estado_t;

    localparam int MSB = LARGURA - 1;

    estado_t            r_estado;
    estado_t            w_proximo;
    logic [1:0]         r_comando;
    logic [1:0]         r_operacao;
    logic [LARGURA-1:0] r_entrada;
    logic [LARGURA-1:0] r_op1;
    logic [LARGURA-1:0] r_op2;
    logic [LARGURA-1:0] r_res;
    logic               r_flag;
    logic [LARGURA-1:0] r_resultado;
    logic               r_overflow;
    logic               w_subtrai;
    logic [LARGURA-1:0] w_soma;
    logic               w_ovf;

    // Operations 01 and 11 subtract; overflow is judged from operand/result signs.
    assign w_subtrai = r_operacao[0];
    assign w_soma    = w_subtrai ? (r_op1 - r_op2) : (r_op1 + r_op2);
    assign w_ovf     = w_subtrai
                       ? ((r_op1[MSB] != r_op2[MSB]) && (w_soma[MSB] != r_op1[MSB]))
                       : ((r_op1[MSB] == r_op2[MSB]) && (w_soma[MSB] != r_op1[MSB]));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado    <= OCIOSO;
            r_resultado <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_estado <= w_proximo;
            case (r_estado)
                OCIOSO: begin
                    if (i_inicio) begin
                        r_comando  <= i_comando;
                        r_operacao <= i_operacao;
                        r_entrada  <= i_entrada;
                    end
                end
                ESCREVE: begin
                    if (r_comando == 2'b11) begin
                        r_resultado <= '0;
                        r_overflow  <= 1'b0;
                    end
                end
                ESPERA: begin
                    r_op1 <= i_dadoLido1;
                    r_op2 <= i_dadoLido2;
                end
                CALCULA: begin
                    r_res  <= w_soma;
                    r_flag <= w_ovf;
                end
                GRAVA: begin
                    r_resultado <= r_res;
                    r_overflow  <= r_flag;
                end
                default: ;
            endcase
        end
    end

    // Bank-side outputs decode straight from the state so no write follows reset.
    always_comb begin
        w_proximo = r_estado;
        o_escrita = 1'b0;
        o_idReg   = 2'b11;
        o_fonte1  = 2'b11;
        o_fonte2  = 2'b11;
        o_dado    = '0;
        case (r_estado)
            OCIOSO: begin
                if (i_inicio) begin
                    w_proximo = (i_comando == 2'b10) ? LE : ESCREVE;
                end
            end
            ESCREVE: begin
                o_escrita = 1'b1;
                o_idReg   = (r_comando == 2'b11) ? 2'b10 : r_comando;
                o_dado    = (r_comando == 2'b11) ? '0 : r_entrada;
                w_proximo = FIM;
            end
            LE, ESPERA: begin
                o_fonte1  = r_operacao[1] ? 2'b10 : 2'b00;
                o_fonte2  = (r_operacao == 2'b10) ? 2'b00 : 2'b01;
                w_proximo = (r_estado == LE) ? ESPERA : CALCULA;
            end
            CALCULA: begin
                w_proximo = GRAVA;
            end
            GRAVA: begin
                o_escrita = 1'b1;
                o_idReg   = 2'b10;
                o_dado    = r_res;
                w_proximo = FIM;
            end
            FIM: begin
                w_proximo = OCIOSO;
            end
            default: begin
                w_proximo = OCIOSO;
            end
        endcase
    end

    assign o_ocupado   = (r_estado != OCIOSO);
    assign o_pronto    = (r_estado == FIM);
    assign o_resultado = r_resultado;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_controle_calc.sv
// Bench for controle_calc: a behavioural register bank plus a command-level
// reference model checked against every DUT output on every cycle.
module tb_controle_calc;

    localparam int LARGURA = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inicio = 1'b1;
    logic [1:0]  comando = 2'b00;
    logic [1:0]  operacao = 2'b00;
    logic [31:0] entrada = 32'd0;
    logic [31:0] dadoLido1 = 32'd0;
    logic [31:0] dadoLido2 = 32'd0;
    logic        ocupado, pronto, overflow, escrita;
    logic [31:0] resultado, dado;
    logic [1:0]  idReg, fonte1, fonte2;

    logic [31:0] bank [4];

    int checks = 0;
    int errors = 0;
    int prontoCount = 0;

    // Reference model state: phase is the cycle index since the accepting edge.
    int          phase = 0;
    bit          modelArmed = 0;
    logic [1:0]  mCmd = 2'b00;
    logic [1:0]  mOp = 2'b00;
    logic [31:0] mVal = 32'd0;
    logic [31:0] mA = 32'd0, mB = 32'd0, mAcc = 32'd0;
    logic [31:0] expRes = 32'd0;
    logic        expOvf = 1'b0;
    logic [31:0] mNewRes = 32'd0;
    logic        mNewOvf = 1'b0;
    longint      mX, mY, mR;

    always #5 clock = ~clock;

    controle_calc #(.LARGURA(LARGURA)) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_inicio    (inicio),
        .i_comando   (comando),
        .i_operacao  (operacao),
        .i_entrada   (entrada),
        .i_dadoLido1 (dadoLido1),
        .i_dadoLido2 (dadoLido2),
        .o_ocupado   (ocupado),
        .o_pronto    (pronto),
        .o_resultado (resultado),
        .o_overflow  (overflow),
        .o_idReg     (idReg),
        .o_escrita   (escrita),
        .o_dado      (dado),
        .o_fonte1    (fonte1),
        .o_fonte2    (fonte2)
    );

    // Register bank: writes land on the falling edge, reads sample on the rising edge.
    initial begin
        for (int i = 0; i < 4; i++) bank[i] = 32'd0;
    end

    always @(negedge clock) begin
        if (escrita === 1'b1 && idReg != 2'b11) bank[idReg] <= dado;
    end

    always @(posedge clock) begin
        if (escrita !== 1'b1) begin
            dadoLido1 <= (fonte1 == 2'b11) ? 32'd0 : bank[fonte1];
            dadoLido2 <= (fonte2 == 2'b11) ? 32'd0 : bank[fonte2];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Command-level model: computes results from architectural A/B/Acc at accept time.
    always @(posedge clock) begin
        if (reset) begin
            phase = 0;
            expRes = 32'd0;
            expOvf = 1'b0;
            modelArmed = 1;
        end else if (phase == 0) begin
            if (inicio) begin
                mCmd = comando;
                mOp = operacao;
                mVal = entrada;
                phase = 1;
                if (mCmd == 2'b10) begin
                    case (mOp)
                        2'b00: begin mX = longint'($signed(mA));   mY = longint'($signed(mB)); mR = mX + mY; end
                        2'b01: begin mX = longint'($signed(mA));   mY = longint'($signed(mB)); mR = mX - mY; end
                        2'b10: begin mX = longint'($signed(mAcc)); mY = longint'($signed(mA)); mR = mX + mY; end
                        default: begin mX = longint'($signed(mAcc)); mY = longint'($signed(mB)); mR = mX - mY; end
                    endcase
                    mNewRes = mR[31:0];
                    mNewOvf = (mR > 64'sd2147483647) || (mR < -64'sd2147483648);
                end
            end
        end else begin
            if (mCmd != 2'b10 && phase == 1) begin
                case (mCmd)
                    2'b00: mA = mVal;
                    2'b01: mB = mVal;
                    default: begin
                        mAcc = 32'd0;
                        expRes = 32'd0;
                        expOvf = 1'b0;
                    end
                endcase
            end
            if (mCmd == 2'b10 && phase == 4) begin
                mAcc = mNewRes;
                expRes = mNewRes;
                expOvf = mNewOvf;
            end
            phase = (phase == ((mCmd == 2'b10) ? 5 : 2)) ? 0 : phase + 1;
        end
    end

    // Per-cycle comparison, sampled 1 time unit after the rising edge.
    always @(posedge clock) begin
        logic [1:0]  eId, eF1, eF2;
        logic [31:0] eDado;
        logic        eEsc, eOcu, ePro;
        #1;
        if (pronto === 1'b1) prontoCount++;
        if (modelArmed) begin
            eId = 2'b11; eF1 = 2'b11; eF2 = 2'b11; eDado = 32'd0;
            eEsc = 1'b0; ePro = 1'b0;
            eOcu = (phase != 0);
            if (mCmd != 2'b10) begin
                if (phase == 1) begin
                    eEsc = 1'b1;
                    eId = (mCmd == 2'b11) ? 2'b10 : mCmd;
                    eDado = (mCmd == 2'b11) ? 32'd0 : mVal;
                end
                if (phase == 2) ePro = 1'b1;
            end else begin
                if (phase == 1 || phase == 2) begin
                    case (mOp)
                        2'b00, 2'b01: begin eF1 = 2'b00; eF2 = 2'b01; end
                        2'b10:        begin eF1 = 2'b10; eF2 = 2'b00; end
                        default:      begin eF1 = 2'b10; eF2 = 2'b01; end
                    endcase
                end
                if (phase == 4) begin
                    eEsc = 1'b1;
                    eId = 2'b10;
                    eDado = mNewRes;
                end
                if (phase == 5) ePro = 1'b1;
            end
            checkOutput("ocupado", 32'(ocupado), 32'(eOcu));
            checkOutput("pronto", 32'(pronto), 32'(ePro));
            checkOutput("escrita", 32'(escrita), 32'(eEsc));
            checkOutput("idReg", 32'(idReg), 32'(eId));
            checkOutput("dado", dado, eDado);
            checkOutput("fonte1", 32'(fonte1), 32'(eF1));
            checkOutput("fonte2", 32'(fonte2), 32'(eF2));
            checkOutput("resultado", resultado, expRes);
            checkOutput("overflow", 32'(overflow), 32'(expOvf));
        end
    end

    // Issues one command from a falling edge in OCIOSO and returns at the next idle falling edge.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [1:0] op, input logic [31:0] val, input bit noise);
        int len;
        comando = cmd;
        operacao = op;
        entrada = val;
        inicio = 1'b1;
        len = (cmd == 2'b10) ? 6 : 3;
        for (int i = 1; i <= len; i++) begin
            @(negedge clock);
            if (noise && i < len) begin
                inicio = 1'($urandom_range(0, 1));
                comando = 2'($urandom_range(0, 3));
                entrada = $urandom;
            end else begin
                inicio = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] randomOperand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'(int'($urandom_range(0, 20)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int prontoStart;

        // Reset held two cycles with Inicio high.
        repeat (2) @(negedge clock);
        checkOutput("reset ocupado", 32'(ocupado), 32'd0);
        checkOutput("reset escrita", 32'(escrita), 32'd0);
        checkOutput("reset idReg", 32'(idReg), 32'd3);
        checkOutput("reset resultado", resultado, 32'd0);
        reset = 1'b0;
        inicio = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("no pronto after reset", 32'(prontoCount), 32'd0);

        applyStimulus(2'b00, 2'b00, 32'd5, 0);
        applyStimulus(2'b01, 2'b00, 32'd3, 0);
        applyStimulus(2'b10, 2'b00, 32'd0, 0);
        checkOutput("5+3 resultado", resultado, 32'd8);
        checkOutput("5+3 overflow", 32'(overflow), 32'd0);

        applyStimulus(2'b00, 2'b00, 32'd3, 0);
        applyStimulus(2'b01, 2'b00, 32'd5, 0);
        applyStimulus(2'b10, 2'b01, 32'd0, 0);
        checkOutput("3-5 resultado", resultado, 32'hFFFFFFFE);
        checkOutput("3-5 overflow", 32'(overflow), 32'd0);

        applyStimulus(2'b00, 2'b00, 32'h80000000, 0);
        applyStimulus(2'b01, 2'b00, 32'd1, 0);
        applyStimulus(2'b10, 2'b01, 32'd0, 0);
        checkOutput("min-1 resultado", resultado, 32'h7FFFFFFF);
        checkOutput("min-1 overflow", 32'(overflow), 32'd1);

        applyStimulus(2'b00, 2'b00, 32'h7FFFFFFF, 0);
        applyStimulus(2'b10, 2'b00, 32'd0, 0);
        checkOutput("max+1 resultado", resultado, 32'h80000000);
        checkOutput("max+1 overflow", 32'(overflow), 32'd1);

        applyStimulus(2'b11, 2'b00, 32'hDEADBEEF, 0);
        checkOutput("clear resultado", resultado, 32'd0);
        checkOutput("clear overflow", 32'(overflow), 32'd0);
        checkOutput("clear bank acc", bank[2], 32'd0);

        // Three accumulates with Inicio held high the whole time.
        applyStimulus(2'b00, 2'b00, 32'd10, 0);
        comando = 2'b10;
        operacao = 2'b10;
        inicio = 1'b1;
        prontoStart = prontoCount;
        repeat (18) @(negedge clock);
        inicio = 1'b0;
        checkOutput("held inicio pronto count", 32'(prontoCount - prontoStart), 32'd3);
        checkOutput("held inicio resultado", resultado, 32'd30);

        // Reset asserted during ESPERA of an operate.
        @(negedge clock);
        prontoStart = prontoCount;
        comando = 2'b10;
        operacao = 2'b00;
        inicio = 1'b1;
        @(negedge clock);
        inicio = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort ocupado", 32'(ocupado), 32'd0);
        repeat (4) @(negedge clock);
        checkOutput("abort ocupado later", 32'(ocupado), 32'd0);
        checkOutput("abort pronto count", 32'(prontoCount - prontoStart), 32'd0);
        checkOutput("abort bank acc", bank[2], 32'd30);
        applyStimulus(2'b10, 2'b10, 32'd0, 0);
        checkOutput("after abort resultado", resultado, 32'd40);

        // Randomized commands with noise on Inicio while busy.
        for (int n = 0; n < 80; n++) begin
            logic [1:0] cmd;
            cmd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 4) cmd = 2'b10;
            applyStimulus(cmd, 2'($urandom_range(0, 3)), randomOperand(), 1);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
